// File: rtl/led_blinker_mc_if.sv
// LED blinker control/status bundle: per-channel enables and modes in, LED drive and tick out.
// No latency of its own; carries plain level signals between controller and blinker.
// No backpressure: every signal is sampled or driven every cycle.
interface led_blinker_mc_if #(
  parameter int NUM_CH = 4,
  parameter int HP_W   = 10
);
  logic [NUM_CH-1:0]   ch_en;
  logic [2*NUM_CH-1:0] ch_mode;
  logic [HP_W-1:0]     half_period;
  logic [NUM_CH-1:0]   led_out;
  logic                tick_o;

  modport master (output ch_en, ch_mode, half_period, input led_out, tick_o);
  modport slave  (input ch_en, ch_mode, half_period, output led_out, tick_o);
endinterface

// File: rtl/led_blinker_mc.sv
// Multi-channel LED blinker: blink / solid / fast / double-flash per channel off a shared tick.
// Latency: led_out follows an enable by 1 cycle; pattern edges land on prescaler ticks.
// No backpressure; optional LED_BLINKER_MC_PHASE_SYNC_EN puts blink/fast channels on shared waves.
module led_blinker_mc #(
  parameter int NUM_CH   = 4,
  parameter int TICK_DIV = 50000,
  parameter int HP_W     = 10,
  parameter int CNT_W    = 16
) (
  input  logic               pclk,
  input  logic               preset,
  led_blinker_mc_if.slave    bus
);
  localparam int TC_W = HP_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_F1, S_G1, S_F2, S_REST} state_t;

  logic [CNT_W-1:0]  r_presc;
  logic              w_tick;
  logic [TC_W-1:0]   w_h;
  logic [TC_W-1:0]   w_hq;
  logic [TC_W-1:0]   w_rest;

  state_t            r_state     [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [TC_W-1:0]   r_tc        [NUM_CH];
  logic [TC_W-1:0]   w_tc_nxt    [NUM_CH];
  logic [TC_W-1:0]   w_len       [NUM_CH];
  logic [1:0]        r_mode      [NUM_CH];
  logic [1:0]        w_mode      [NUM_CH];
  logic [NUM_CH-1:0] r_led;
  logic [NUM_CH-1:0] w_led_nxt;

  assign w_tick      = (r_presc == CNT_W'(TICK_DIV - 1));
  assign bus.tick_o  = w_tick;
  assign bus.led_out = r_led;

  // Shared prescaler: 0..TICK_DIV-1, tick on the terminal count.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)      r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Effective phase lengths in ticks; zero half-period behaves as one tick.
  always_comb begin
    w_h    = (bus.half_period == '0) ? TC_W'(1) : TC_W'(bus.half_period);
    w_hq   = ((w_h >> 2) == '0) ? TC_W'(1) : (w_h >> 2);
    w_rest = (w_hq << 2) + w_hq;
  end

`ifdef LED_BLINKER_MC_PHASE_SYNC_EN
  logic [TC_W-1:0] r_gb_cnt, w_gb_cnt_nxt, r_gf_cnt, w_gf_cnt_nxt;
  logic            r_gb_wave, w_gb_nxt, r_gf_wave, w_gf_nxt;

  // Global blink/fast square waves, free-running from reset so all channels share phase.
  always_comb begin
    w_gb_cnt_nxt = r_gb_cnt;
    w_gf_cnt_nxt = r_gf_cnt;
    w_gb_nxt     = r_gb_wave;
    w_gf_nxt     = r_gf_wave;
    if (w_tick) begin
      if (r_gb_cnt >= w_h - 1'b1) begin
        w_gb_cnt_nxt = '0;
        w_gb_nxt     = ~r_gb_wave;
      end else begin
        w_gb_cnt_nxt = r_gb_cnt + 1'b1;
      end
      if (r_gf_cnt >= w_hq - 1'b1) begin
        w_gf_cnt_nxt = '0;
        w_gf_nxt     = ~r_gf_wave;
      end else begin
        w_gf_cnt_nxt = r_gf_cnt + 1'b1;
      end
    end
  end

  // Global wave registers; waves start high so a fresh enable lights immediately.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_gb_cnt  <= '0;
      r_gf_cnt  <= '0;
      r_gb_wave <= 1'b1;
      r_gf_wave <= 1'b1;
    end else begin
      r_gb_cnt  <= w_gb_cnt_nxt;
      r_gf_cnt  <= w_gf_cnt_nxt;
      r_gb_wave <= w_gb_nxt;
      r_gf_wave <= w_gf_nxt;
    end
  end
`endif

  // Per-channel next state: disable beats restart beats solid-hold beats tick advance.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_mode[i]      = bus.ch_mode[2*i +: 2];
      w_state_nxt[i] = r_state[i];
      w_tc_nxt[i]    = r_tc[i];
      case (r_state[i])
        S_ON, S_OFF: w_len[i] = (w_mode[i] == 2'b10) ? w_hq : w_h;
        S_REST:      w_len[i] = w_rest;
        default:     w_len[i] = w_hq;
      endcase

      if (!bus.ch_en[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_tc_nxt[i]    = '0;
      end else if (r_state[i] == S_IDLE || w_mode[i] != r_mode[i]) begin
        w_state_nxt[i] = (w_mode[i] == 2'b11) ? S_F1 : S_ON;
        w_tc_nxt[i]    = '0;
      end else if (w_mode[i] == 2'b01) begin
        w_state_nxt[i] = S_ON;
        w_tc_nxt[i]    = '0;
      end else if (w_tick) begin
        // >= so a shrinking half-period ends the phase at the next tick instead of wrapping
        if (r_tc[i] >= w_len[i] - 1'b1) begin
          w_tc_nxt[i] = '0;
          case (r_state[i])
            S_ON:    w_state_nxt[i] = S_OFF;
            S_OFF:   w_state_nxt[i] = S_ON;
            S_F1:    w_state_nxt[i] = S_G1;
            S_G1:    w_state_nxt[i] = S_F2;
            S_F2:    w_state_nxt[i] = S_REST;
            S_REST:  w_state_nxt[i] = S_F1;
            default: w_state_nxt[i] = S_IDLE;
          endcase
        end else begin
          w_tc_nxt[i] = r_tc[i] + 1'b1;
        end
      end

      w_led_nxt[i] = (w_state_nxt[i] == S_ON) || (w_state_nxt[i] == S_F1) ||
                     (w_state_nxt[i] == S_F2);
`ifdef LED_BLINKER_MC_PHASE_SYNC_EN
      // Blink and fast channels bypass their FSM and follow the shared waves.
      if (bus.ch_en[i] && !w_mode[i][0]) begin
        w_state_nxt[i] = S_IDLE;
        w_tc_nxt[i]    = '0;
        w_led_nxt[i]   = w_mode[i][1] ? w_gf_nxt : w_gb_nxt;
      end
`endif
    end
  end

  // Per-channel state, tick counter, mode copy and registered LED drive.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_tc[i]    <= '0;
        r_mode[i]  <= 2'b00;
      end
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_tc[i]    <= w_tc_nxt[i];
        r_mode[i]  <= w_mode[i];
      end
      r_led <= w_led_nxt;
    end
  end
endmodule

// File: tb/tb_led_blinker_mc.sv
// Scoreboard bench for led_blinker_mc with TICK_DIV=4 (one tick every 4 pclk cycles).
// Expected LED/tick values are queued per cycle by the stimulus; a negedge monitor compares.
// Cycle d counts pclk edges after reset release; ticks are sampled at edges d = 4, 8, 12, ...
module tb_led_blinker_mc;
  localparam int NUM_CH   = 4;
  localparam int TICK_DIV = 4;
  localparam int HP_W     = 10;
  localparam int CNT_W    = 4;

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] led;
    logic              tick_chk;
    logic              tick;
    int                id;
  } exp_t;

  string tname [0:8] = '{"blink_pre", "async_reset", "blink_run", "fast", "hp_zero",
                         "dflash", "priority", "mode_change", "phase"};

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  led_blinker_mc_if #(.NUM_CH(NUM_CH), .HP_W(HP_W)) bus ();

  led_blinker_mc #(
    .NUM_CH  (NUM_CH),
    .TICK_DIV(TICK_DIV),
    .HP_W    (HP_W),
    .CNT_W   (CNT_W)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: every cycle, compare all expectations scheduled for this cycle.
  always @(negedge pclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s expectation for cyc %0d not compared (now cyc %0d)",
                 tname[mon_e.id], mon_e.cyc, cyc);
      end else if (((bus.led_out & mon_e.mask) !== (mon_e.led & mon_e.mask)) ||
                   (mon_e.tick_chk && (bus.tick_o !== mon_e.tick))) begin
        errors++;
        $display("FAIL %s cyc=%0d led_out=%b tick_o=%b required led=%b (mask %b) tick=%b",
                 tname[mon_e.id], cyc, bus.led_out, bus.tick_o, mon_e.led, mon_e.mask,
                 mon_e.tick_chk ? mon_e.tick : bus.tick_o);
      end
    end
  end

  task automatic push(input int c, input logic [NUM_CH-1:0] m, input logic [NUM_CH-1:0] v,
                      input logic tc, input logic t, input int id);
    exp_t e;
    e.cyc = c; e.mask = m; e.led = v; e.tick_chk = tc; e.tick = t; e.id = id;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Hold reset one cycle with the given inputs, release; r = cycle index of the release point.
  task automatic start(input logic [NUM_CH-1:0] en, input logic [2*NUM_CH-1:0] mode,
                       input logic [HP_W-1:0] hp, output int r);
    @(posedge pclk);
    #1;
    preset = 1'b1;
    bus.ch_en = en;
    bus.ch_mode = mode;
    bus.half_period = hp;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    r = cyc;
  endtask

  // Free-running blink from enable at d=0: first phase d=1..L-1, then L-cycle phases.
  function automatic logic blink_v(input int d, input int l);
    return (d != 0) && (((d / l) % 2) == 0);
  endfunction

  // Double flash with Hq=1 tick: on 4, off 4, on 4, off 20 cycles.
  function automatic logic df_v(input int d);
    int p;
    p = d % 32;
    return (d != 0) && ((p < 4) || (p >= 8 && p < 12));
  endfunction

  initial begin
    int r, s;
    logic [NUM_CH-1:0] v;
    bus.ch_en = '0;
    bus.ch_mode = '0;
    bus.half_period = '0;

    // Blink H=3, then asynchronous reset in the middle of an ON phase and restart.
    start(4'b0001, 8'h00, 10'd3, r);
    for (int d = 0; d < 30; d++)
      push(r + d, 4'b0001, blink_v(d, 12) ? 4'b0001 : 4'b0000, 1'b1, (d % 4) == 3, 0);
    wait_until(r + 30);
    preset = 1'b1;
    push(r + 30, 4'b1111, 4'b0000, 1'b1, 1'b0, 1);
    wait_until(r + 32);
    preset = 1'b0;
    s = cyc;
    for (int d = 0; d <= 60; d++)
      push(s + d, 4'b0001, blink_v(d, 12) ? 4'b0001 : 4'b0000, 1'b1, (d % 4) == 3, 2);
    wait_until(s + 61);

    // Fast mode H=8 -> 2-tick phases; then H=0 in blink -> 1-tick phases.
    start(4'b0001, 8'h02, 10'd8, r);
    for (int d = 0; d <= 40; d++)
      push(r + d, 4'b0001, blink_v(d, 8) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 3);
    wait_until(r + 41);
    start(4'b0001, 8'h00, 10'd0, r);
    for (int d = 0; d <= 24; d++)
      push(r + d, 4'b0001, blink_v(d, 4) ? 4'b0001 : 4'b0000, 1'b1, (d % 4) == 3, 4);
    wait_until(r + 25);

    // Double flash H=4 (Hq=1).
    start(4'b0001, 8'h03, 10'd4, r);
    for (int d = 0; d <= 70; d++)
      push(r + d, 4'b0001, df_v(d) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 5);
    wait_until(r + 71);

    // Priority: ch1 disabled at the tick edge d=8 together with a mode change to solid;
    // ch0 keeps blinking; ch1 re-enabled (solid) at d=31.
    start(4'b0011, 8'h00, 10'd3, r);
    for (int d = 0; d <= 60; d++) begin
      v = '0;
      v[0] = blink_v(d, 12);
      v[1] = (d < 8) ? blink_v(d, 12) : (d >= 31);
      push(r + d, 4'b0011, v, 1'b0, 1'b0, 6);
    end
    wait_until(r + 7);
    bus.ch_en[1] = 1'b0;
    bus.ch_mode[3:2] = 2'b01;
    wait_until(r + 30);
    bus.ch_en[1] = 1'b1;
    wait_until(r + 61);

    // Mode change 00 -> 11 during OFF: restart in F1 at d=15, G1 at 16, F2 at 20, REST at 24.
    start(4'b0001, 8'h00, 10'd3, r);
    for (int d = 0; d <= 27; d++) begin
      v = '0;
      if (d <= 14) v[0] = blink_v(d, 12);
      else         v[0] = (d == 15) || (d >= 20 && d < 24);
      push(r + d, 4'b0001, v, 1'b0, 1'b0, 7);
    end
    wait_until(r + 14);
    bus.ch_mode[1:0] = 2'b11;
    wait_until(r + 28);

    // Phase relation: ch0 enabled at release, ch2 enabled five cycles later (lit from d=6).
    start(4'b0001, 8'h00, 10'd3, r);
    for (int d = 0; d <= 50; d++) begin
      v = '0;
      v[0] = blink_v(d, 12);
`ifdef LED_BLINKER_MC_PHASE_SYNC_EN
      v[2] = (d >= 6) && (((d / 12) % 2) == 0);
`else
      v[2] = (d >= 6) && ((((d - 4) / 12) % 2) == 0);
`endif
      push(r + d, 4'b0101, v, 1'b0, 1'b0, 8);
    end
    wait_until(r + 5);
    bus.ch_en[2] = 1'b1;
    wait_until(r + 52);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
